prf_write_arbiter: RTL and testbench

//  Collects writeback requests from the PRF_WR_COUNT (7) write requestors (ALU/mul/div/LSQ pipes) and

---
 rtl/core_types_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/prf_write_arbiter.sv | 97 +++++++++
 tb/tb_prf_write_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types for the physical register file write path: widths, index types and
// the bank mapping of a physical register.
package core_types_pkg;
    localparam int PRF_WR_COUNT       = 7;
    localparam int LOG_PRF_WR_COUNT   = $clog2(PRF_WR_COUNT);
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = 2;
    localparam int PR_COUNT           = 128;
    localparam int LOG_PR_COUNT       = 7;
    localparam int ROB_ENTRIES        = 128;
    localparam int LOG_ROB_ENTRIES    = 7;
    localparam int XLEN               = 32;

    typedef logic [LOG_PR_COUNT-1:0]       pr_t;
    typedef logic [LOG_ROB_ENTRIES-1:0]    rob_index_t;
    typedef logic [LOG_PRF_BANK_COUNT-1:0] prf_bank_t;
    typedef logic [LOG_PRF_WR_COUNT-1:0]   wr_ptr_t;

    // Banks interleave on the low PR bits so consecutive PRs land in different banks.
    function automatic prf_bank_t prf_bank_of(pr_t pr);
        return pr[LOG_PRF_BANK_COUNT-1:0];
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int REQ_COUNT = 7,
    parameter int PTR_W     = $clog2(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] req_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic [REQ_COUNT-1:0] grant_o
);
    int   idx;
    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            idx = (int'(ptr_i) + k) % REQ_COUNT;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/prf_write_arbiter.sv
// Per-bank round-robin arbitration of writeback requests into the PRF write ports, with the
// completion broadcast driven from the same output registers.
module prf_write_arbiter
    import core_types_pkg::*;
(
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [PRF_WR_COUNT-1:0]                WB_valid_by_wr,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]      WB_data_by_wr,
    input  pr_t  [PRF_WR_COUNT-1:0]                WB_PR_by_wr,
    input  rob_index_t [PRF_WR_COUNT-1:0]          WB_ROB_index_by_wr,
    output logic [PRF_WR_COUNT-1:0]                WB_ready_by_wr,
    output logic [PRF_BANK_COUNT-1:0]              prf_wr_valid_by_bank,
    output pr_t  [PRF_BANK_COUNT-1:0]              prf_wr_PR_by_bank,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]    prf_wr_data_by_bank,
    output logic [PRF_BANK_COUNT-1:0]              complete_valid_by_bank,
    output pr_t  [PRF_BANK_COUNT-1:0]              complete_PR_by_bank,
    output rob_index_t [PRF_BANK_COUNT-1:0]        complete_ROB_index_by_bank
);
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] req;
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] grant;
    logic [PRF_WR_COUNT-1:0]                     ready;

    wr_ptr_t    [PRF_BANK_COUNT-1:0]           ptr_q, ptr_d;
    logic       [PRF_BANK_COUNT-1:0]           valid_q, valid_d;
    pr_t        [PRF_BANK_COUNT-1:0]           pr_q, pr_d;
    logic       [PRF_BANK_COUNT-1:0][XLEN-1:0] data_q, data_d;
    rob_index_t [PRF_BANK_COUNT-1:0]           rob_q, rob_d;

    always_comb begin
        req = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                req[b][i] = WB_valid_by_wr[i] && (prf_bank_of(WB_PR_by_wr[i]) == prf_bank_t'(b));
            end
        end
    end

    for (genvar gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank
        rr_arbiter #(.REQ_COUNT(PRF_WR_COUNT)) u_arb (
            .req_i   (req[gb]),
            .ptr_i   (ptr_q[gb]),
            .grant_o (grant[gb])
        );
    end

    // Grants are one-hot per bank, so OR-ing the gated fields is the winner's mux.
    always_comb begin
        ready   = '0;
        ptr_d   = ptr_q;
        valid_d = '0;
        pr_d    = '0;
        data_d  = '0;
        rob_d   = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            valid_d[b] = |grant[b];
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (grant[b][i]) begin
                    ready[i]  = 1'b1;
                    ptr_d[b]  = wr_ptr_t'((i + 1) % PRF_WR_COUNT);
                    pr_d[b]   = pr_d[b] | WB_PR_by_wr[i];
                    data_d[b] = data_d[b] | WB_data_by_wr[i];
                    rob_d[b]  = rob_d[b] | WB_ROB_index_by_wr[i];
                end
            end
        end
    end

    assign WB_ready_by_wr = RST ? '0 : ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q   <= '0;
            valid_q <= '0;
            pr_q    <= '0;
            data_q  <= '0;
            rob_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (valid_d[b]) begin
                    pr_q[b]   <= pr_d[b];
                    data_q[b] <= data_d[b];
                    rob_q[b]  <= rob_d[b];
                end
            end
        end
    end

    assign prf_wr_valid_by_bank       = valid_q;
    assign prf_wr_PR_by_bank          = pr_q;
    assign prf_wr_data_by_bank        = data_q;
    assign complete_valid_by_bank     = valid_q;
    assign complete_PR_by_bank        = pr_q;
    assign complete_ROB_index_by_bank = rob_q;
endmodule

// File: tb/tb_prf_write_arbiter.sv
// Bench for prf_write_arbiter: a per-bank round-robin model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_prf_write_arbiter;
    import core_types_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    logic [PRF_WR_COUNT-1:0]                 WB_valid_by_wr;
    logic [PRF_WR_COUNT-1:0][XLEN-1:0]       WB_data_by_wr;
    pr_t  [PRF_WR_COUNT-1:0]                 WB_PR_by_wr;
    rob_index_t [PRF_WR_COUNT-1:0]           WB_ROB_index_by_wr;
    logic [PRF_WR_COUNT-1:0]                 WB_ready_by_wr;
    logic [PRF_BANK_COUNT-1:0]               prf_wr_valid_by_bank;
    pr_t  [PRF_BANK_COUNT-1:0]               prf_wr_PR_by_bank;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]     prf_wr_data_by_bank;
    logic [PRF_BANK_COUNT-1:0]               complete_valid_by_bank;
    pr_t  [PRF_BANK_COUNT-1:0]               complete_PR_by_bank;
    rob_index_t [PRF_BANK_COUNT-1:0]         complete_ROB_index_by_bank;

    prf_write_arbiter dut (
        .CLK                        (CLK),
        .RST                        (RST),
        .WB_valid_by_wr             (WB_valid_by_wr),
        .WB_data_by_wr              (WB_data_by_wr),
        .WB_PR_by_wr                (WB_PR_by_wr),
        .WB_ROB_index_by_wr         (WB_ROB_index_by_wr),
        .WB_ready_by_wr             (WB_ready_by_wr),
        .prf_wr_valid_by_bank       (prf_wr_valid_by_bank),
        .prf_wr_PR_by_bank          (prf_wr_PR_by_bank),
        .prf_wr_data_by_bank        (prf_wr_data_by_bank),
        .complete_valid_by_bank     (complete_valid_by_bank),
        .complete_PR_by_bank        (complete_PR_by_bank),
        .complete_ROB_index_by_bank (complete_ROB_index_by_bank)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    logic check_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: winner of a bank is the candidate with the smallest forward distance from ptr.
    int mptr[PRF_BANK_COUNT];
    int mwin[PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0] mready;
    logic [PRF_WR_COUNT-1:0] acc_q;
    logic       ev[PRF_BANK_COUNT];
    pr_t        epr[PRF_BANK_COUNT];
    logic [XLEN-1:0] edata[PRF_BANK_COUNT];
    rob_index_t erob[PRF_BANK_COUNT];

    always_comb begin
        int best;
        int d;
        best = 0;
        d    = 0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            mwin[b] = -1;
            best    = PRF_WR_COUNT;
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (WB_valid_by_wr[i] && (int'(WB_PR_by_wr[i]) % PRF_BANK_COUNT == b)) begin
                    d = (i - mptr[b] + PRF_WR_COUNT) % PRF_WR_COUNT;
                    if (d < best) begin
                        best    = d;
                        mwin[b] = i;
                    end
                end
            end
        end
    end

    always_comb begin
        mready = '0;
        if (!RST) begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (mwin[b] >= 0) mready[mwin[b]] = 1'b1;
            end
        end
    end

    always @(posedge CLK) begin
        if (RST) begin
            acc_q <= '0;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                mptr[b] <= 0; ev[b] <= 1'b0; epr[b] <= '0; edata[b] <= '0; erob[b] <= '0;
            end
        end else begin
            acc_q <= mready;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (mwin[b] >= 0) begin
                    ev[b]    <= 1'b1;
                    epr[b]   <= WB_PR_by_wr[mwin[b]];
                    edata[b] <= WB_data_by_wr[mwin[b]];
                    erob[b]  <= WB_ROB_index_by_wr[mwin[b]];
                    mptr[b]  <= (mwin[b] + 1) % PRF_WR_COUNT;
                end else begin
                    ev[b] <= 1'b0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (check_on) begin
            chk("ready", 64'(WB_ready_by_wr), 64'(mready));
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                chk($sformatf("prf_valid[%0d]", b), 64'(prf_wr_valid_by_bank[b]), 64'(ev[b]));
                chk($sformatf("cmp_valid[%0d]", b), 64'(complete_valid_by_bank[b]), 64'(ev[b]));
                chk($sformatf("prf_pr[%0d]", b), 64'(prf_wr_PR_by_bank[b]), 64'(epr[b]));
                chk($sformatf("cmp_pr[%0d]", b), 64'(complete_PR_by_bank[b]), 64'(epr[b]));
                chk($sformatf("prf_data[%0d]", b), 64'(prf_wr_data_by_bank[b]), 64'(edata[b]));
                chk($sformatf("cmp_rob[%0d]", b), 64'(complete_ROB_index_by_bank[b]), 64'(erob[b]));
            end
        end
    end

    task automatic set_req(input int i, input int p);
        WB_valid_by_wr[i]     = 1'b1;
        WB_PR_by_wr[i]        = pr_t'(p);
        WB_data_by_wr[i]      = 32'hA500_0000 ^ 32'(i << 12) ^ 32'(p);
        WB_ROB_index_by_wr[i] = rob_index_t'((i * 17 + p) % 128);
    endtask

    // Advance one cycle; requestors drop valid once accepted.
    task automatic step();
        @(posedge CLK);
        #1;
        WB_valid_by_wr = WB_valid_by_wr & ~acc_q;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 30 && WB_valid_by_wr != '0; k++) step();
        chk(name, 64'(WB_valid_by_wr), 64'd0);
    endtask

    initial begin
        RST                = 1'b1;
        WB_valid_by_wr     = '0;
        WB_data_by_wr      = '0;
        WB_PR_by_wr        = '0;
        WB_ROB_index_by_wr = '0;

        // Reset held 3 cycles with every requestor valid.
        for (int i = 0; i < PRF_WR_COUNT; i++) set_req(i, i);
        @(posedge CLK);
        #1;
        check_on = 1'b1;
        chk("rst_ready", 64'(WB_ready_by_wr), 64'd0);
        chk("rst_valid", 64'(prf_wr_valid_by_bank), 64'd0);
        chk("rst_pr0", 64'(complete_PR_by_bank[0]), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("post_rst_ready", 64'(WB_ready_by_wr), 64'(7'b0001111));
        step();
        #1;
        chk("post_rst_ready2", 64'(WB_ready_by_wr), 64'(7'b1110000));
        chk("post_rst_outv", 64'(prf_wr_valid_by_bank), 64'hF);
        drain("drain_t1");
        step();

        // Distinct banks: all granted at once, outputs one cycle later.
        for (int i = 0; i < 4; i++) set_req(i, 4 + i);
        #1;
        chk("t2_ready", 64'(WB_ready_by_wr), 64'(7'b0001111));
        step();
        #1;
        chk("t2_valid", 64'(prf_wr_valid_by_bank), 64'hF);
        chk("t2_pr3", 64'(prf_wr_PR_by_bank[3]), 64'd7);
        chk("t2_pr0", 64'(complete_PR_by_bank[0]), 64'd4);
        chk("t2_rob0", 64'(complete_ROB_index_by_bank[0]), 64'd4);
        chk("t2_rob1", 64'(complete_ROB_index_by_bank[1]), 64'd22);
        chk("t2_rob2", 64'(complete_ROB_index_by_bank[2]), 64'd40);
        chk("t2_rob3", 64'(complete_ROB_index_by_bank[3]), 64'd58);
        step();

        // RR fairness in bank 1: move ptr[1] to 5, then wr2 vs wr6.
        set_req(4, 1);
        step();
        set_req(2, 9);
        set_req(6, 13);
        #1;
        chk("t4_ready_a", 64'(WB_ready_by_wr), 64'(7'b1000000));
        step();
        #1;
        chk("t4_ready_b", 64'(WB_ready_by_wr), 64'(7'b0000100));
        chk("t4_pr_a", 64'(complete_PR_by_bank[1]), 64'd13);
        step();
        #1;
        chk("t4_pr_b", 64'(complete_PR_by_bank[1]), 64'd9);

        // Idle: valids drop, data holds, pointers unchanged.
        step();
        step();
        #1;
        chk("t5_valid", 64'(prf_wr_valid_by_bank), 64'd0);
        chk("t5_hold_pr1", 64'(prf_wr_PR_by_bank[1]), 64'd9);
        chk("t5_hold_pr3", 64'(prf_wr_PR_by_bank[3]), 64'd7);
        set_req(1, 6);
        set_req(4, 2);
        #1;
        chk("t5_ptr_hold", 64'(WB_ready_by_wr), 64'(7'b0010000));
        drain("drain_t5");
        step();

        // Clean reset so bank 0 starts from wr0.
        RST = 1'b1;
        step();
        RST = 1'b0;

        // Same-bank contention with a reset mid-stream.
        for (int i = 0; i < PRF_WR_COUNT; i++) set_req(i, 8);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t6_pre_grant%0d", k), 64'(WB_ready_by_wr), 64'(1 << k));
            step();
        end
        RST = 1'b1;
        for (int i = 0; i < PRF_WR_COUNT; i++) set_req(i, 8);
        #1;
        chk("t6_rst_ready", 64'(WB_ready_by_wr), 64'd0);
        step();
        RST = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(prf_wr_valid_by_bank), 64'd0);
        for (int k = 0; k < PRF_WR_COUNT; k++) begin
            chk($sformatf("t3_grant%0d", k), 64'(WB_ready_by_wr), 64'(1 << k));
            step();
            #1;
        end
        chk("t3_drained", 64'(WB_valid_by_wr), 64'd0);
        chk("t3_last_pr", 64'(prf_wr_PR_by_bank[0]), 64'd8);
        set_req(0, 8);
        set_req(6, 8);
        #1;
        chk("t3_wrap", 64'(WB_ready_by_wr), 64'(7'b0000001));
        drain("drain_t3");
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
